game_tick_ctrl: RTL and testbench
=================================

Name: game_tick_ctrl

Overview:
- Front-end producer for the scoreboard clock display logic.
- Turns the board system clock and raw push-buttons into the slow signals the display logic consumes: `toggle` (1 s tick, sampled on its rising edge) and `possession` (level, rising-edge detected at tick edges by the consumer).
- Owns run/stop of the game clock and stops ticking when the game time expires.
- Mirrors remaining game seconds for status LEDs and debug.

Parameters:
- CLK_HZ, 50000000, system clock cycles per tick period; must be even, ≥ 4.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a button level.
- GAME_SECS, 600, game length in seconds; fits in 10 bits.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_run_n  input  1  raw run/stop key, active-low, asynchronous.
- btn_poss_n  input  1  raw possession-change key, active-low, asynchronous.
- toggle  output  1  1 s tick square wave to the display clock logic.
- possession  output  1  possession-change request level.
- running  output  1  high in RUN state.
- expired  output  1  high in EXPIRED state.
- secs_left  output  10  remaining game seconds.

Behaviour:
- Reset (async assert, sync release):
  - state = STOP; prescaler = 0; toggle = 0; possession = 0; running = 0; expired = 0; secs_left = GAME_SECS.
  - Both debounced levels = 1 (released).
- Input conditioning, per button:
  - Two-flop synchronizer.
  - Debounce counter: resets whenever the synced sample differs from the current debounced level. When it reaches DEBOUNCE_CYCLES-1 with the sample still differing, the debounced level takes the sample.
  - A press event is a single-cycle pulse on a debounced 1→0 transition.
  - Release events are ignored.
  - Press-to-event latency is 2 + DEBOUNCE_CYCLES cycles.
- FSM states: STOP, RUN, EXPIRED.
  - STOP + run press → RUN.
  - RUN + run press → STOP.
  - RUN and secs_left reaches 0 → EXPIRED, in the same cycle secs_left becomes 0.
  - EXPIRED: run presses ignored. Only reset leaves EXPIRED.
- Prescaler (0 .. CLK_HZ-1):
  - Advances only in RUN. Frozen in STOP; toggle holds its current value.
  - toggle = 1 for prescaler in [0, CLK_HZ/2-1], 0 otherwise.
  - Entering RUN from reset with prescaler = 0 drives toggle high on the cycle after the transition. The first tick rising edge is therefore 1 cycle after entering RUN.
  - On wrap from CLK_HZ-1 to 0: toggle rises and secs_left decrements by 1, saturating at 0.
  - First rising edge after reset does NOT decrement. A skip-first flag, cleared after the first rise, makes secs_left track the consumer's counter exactly.
  - In EXPIRED: prescaler = 0, toggle = 0.
- Possession:
  - A poss press in STOP or RUN sets possession = 1 the next cycle.
  - Presses while possession = 1, or in EXPIRED, are ignored.
  - possession stays high until the first toggle falling edge that follows at least one toggle rising edge seen with possession = 1. It then clears on that falling-edge cycle.
  - This guarantees the consumer samples possession = 1 at exactly one rising edge and 0 at the next.
  - A press in STOP holds possession high until RUN resumes and the sequence above completes.
- Simultaneous events:
  - Run press and wrap in the same RUN cycle: the wrap is applied (toggle rises, secs_left decrements), then state → STOP.
  - secs_left reaching 0 and a run press in the same cycle: EXPIRED wins.
  - Poss press in the same cycle as the clearing falling edge: ignored. The clear has priority; the request is not re-armed.
- Reset mid-operation: all state returns to reset values immediately, regardless of toggle level.

Test Plan:
Bench parameters: CLK_HZ=10, DEBOUNCE_CYCLES=4, GAME_SECS=3.
1. Reset, then hold btn_run_n low for 8 cycles → running rises 7 cycles after the press edge; toggle is high for 5 cycles, low for 5; secs_left = 3 after the first rise, 2 after the second.
2. Bounce btn_run_n (low 2, high 1, low 2, high) → no press event; state remains STOP; toggle stays 0.
3. Run until expiry → secs_left goes 3, 2, 1, 0; expired = 1 and running = 0 at the 0 transition; toggle stays 0 afterwards; further run presses produce no change.
4. In RUN with toggle low, press poss → possession = 1 at the next cycle, stays through exactly one toggle rise, clears on the following falling edge; a second press while high is ignored.
5. Press run mid-high-phase → toggle frozen at 1, secs_left frozen; press run again → toggle resumes and falls after the remaining high cycles.
6. Assert reset_n low mid-run with possession = 1 → all outputs go to their reset values asynchronously, secs_left = 3.

Source files
------------

// File: rtl/game_tick_ctrl.sv
// Game-clock front end: conditions the run/possession keys, sequences STOP/RUN/EXPIRED,
// and produces the 1 s toggle, possession level and remaining-seconds mirror.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_STOP    | game clock halted; prescaler and toggle frozen
//   ST_RUN     | prescaler advancing; toggle ticking; seconds counting down
//   ST_EXPIRED | game time over; toggle held low; only reset leaves
module game_tick_ctrl #(
   parameter int CLK_HZ          = 50000000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int GAME_SECS       = 600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_run_n,
   input  logic       btn_poss_n,
   output logic       toggle,
   output logic       possession,
   output logic       running,
   output logic       expired,
   output logic [9:0] secs_left
);

   localparam int PW = $clog2(CLK_HZ);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] PRE_HALF  = PW'(CLK_HZ / 2);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [9:0]    SECS_INIT = 10'(GAME_SECS);

   typedef enum logic [1:0] {
      ST_STOP    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync1_q, sync2_q;
   logic [1:0]    deb_q, deb_d;
   logic [1:0]    press_q, press_d;
   logic [DW-1:0] dcnt_q [2];
   logic [DW-1:0] dcnt_d [2];
   logic [PW-1:0] pre_q, pre_d;
   logic [9:0]    secs_q, secs_d;
   logic          tog_q, tog_d;
   logic          skip_q, skip_d;
   logic          poss_q, poss_d;
   logic          seen_q, seen_d;
   logic          run_press, poss_press;
   logic          tog_rise, tog_fall;

   // bit 0 = run key, bit 1 = possession key
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         dcnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (dcnt_q[i] == DEB_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + DW'(1);
            end
         end
      end
      press_d = deb_q & ~deb_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         deb_q   <= 2'b11;
         press_q <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            dcnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= {btn_poss_n, btn_run_n};
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         press_q <= press_d;
         for (int i = 0; i < 2; i++) begin
            dcnt_q[i] <= dcnt_d[i];
         end
      end
   end

   assign run_press  = press_q[0];
   assign poss_press = press_q[1];

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      tog_d   = tog_q;
      secs_d  = secs_q;
      skip_d  = skip_q;
      case (state_q)
         ST_STOP: begin
            if (run_press) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            tog_d = (pre_q < PRE_HALF);
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
            // pre_q == 0 in RUN is the tick rising edge; the first one only arms counting
            if (pre_q == '0) begin
               if (skip_q) begin
                  skip_d = 1'b0;
               end else if (secs_q != 10'd0) begin
                  secs_d = secs_q - 10'd1;
               end
            end
            if (secs_d == 10'd0) begin
               state_d = ST_EXPIRED;
            end else if (run_press) begin
               state_d = ST_STOP;
            end
         end
         ST_EXPIRED: begin
            pre_d = '0;
            tog_d = 1'b0;
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase
   end

   // possession must be seen high at exactly one consumer tick edge, then drop on a fall
   always_comb begin
      tog_rise = ~tog_q & tog_d;
      tog_fall = tog_q & ~tog_d;
      poss_d   = poss_q;
      seen_d   = seen_q;
      if (poss_q) begin
         if (tog_rise) begin
            seen_d = 1'b1;
         end else if (tog_fall && seen_q) begin
            poss_d = 1'b0;
            seen_d = 1'b0;
         end
      end else if (poss_press && (state_q != ST_EXPIRED)) begin
         poss_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_STOP;
         pre_q   <= '0;
         tog_q   <= 1'b0;
         secs_q  <= SECS_INIT;
         skip_q  <= 1'b1;
         poss_q  <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         tog_q   <= tog_d;
         secs_q  <= secs_d;
         skip_q  <= skip_d;
         poss_q  <= poss_d;
         seen_q  <= seen_d;
      end
   end

   assign toggle     = tog_q;
   assign possession = poss_q;
   assign running    = (state_q == ST_RUN);
   assign expired    = (state_q == ST_EXPIRED);
   assign secs_left  = secs_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Bench for game_tick_ctrl: cycle-accurate behavioural model compared every cycle,
// plus directed timelines with hand-derived literal expectations.
module tb_game_tick_ctrl;

   localparam int CLK  = 10;
   localparam int DEB  = 4;
   localparam int GAME = 3;

   logic       clk;
   logic       reset_n;
   logic       btn_run_n;
   logic       btn_poss_n;
   logic       toggle;
   logic       possession;
   logic       running;
   logic       expired;
   logic [9:0] secs_left;

   int checks;
   int failures;

   game_tick_ctrl #(
      .CLK_HZ          (CLK),
      .DEBOUNCE_CYCLES (DEB),
      .GAME_SECS       (GAME)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_run_n  (btn_run_n),
      .btn_poss_n (btn_poss_n),
      .toggle     (toggle),
      .possession (possession),
      .running    (running),
      .expired    (expired),
      .secs_left  (secs_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: state 0=stop 1=run 2=expired; time in RUN counted as total run cycles.
   int m_state;
   int m_runcyc;
   int m_secs;
   bit m_tog;
   bit m_poss;
   bit m_seen;
   bit m_deb   [2];
   bit m_press [2];
   bit hist    [2][DEB+1];

   task automatic model_reset();
      m_state  = 0;
      m_runcyc = 0;
      m_secs   = GAME;
      m_tog    = 1'b0;
      m_poss   = 1'b0;
      m_seen   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_deb[i]   = 1'b1;
         m_press[i] = 1'b0;
         for (int k = 0; k <= DEB; k++) hist[i][k] = 1'b1;
      end
   endtask

   task automatic model_step();
      bit old_tog, run_ev, poss_ev, all_diff, raw;
      int st, rises;
      old_tog = m_tog;
      run_ev  = m_press[0];
      poss_ev = m_press[1];
      st      = m_state;
      if (st == 0) begin
         if (run_ev) m_state = 1;
      end else if (st == 1) begin
         m_runcyc++;
         m_tog  = ((m_runcyc - 1) % CLK) < (CLK / 2);
         rises  = (m_runcyc - 1) / CLK + 1;
         m_secs = (rises - 1 >= GAME) ? 0 : GAME - (rises - 1);
         if (m_secs == 0) m_state = 2;
         else if (run_ev) m_state = 0;
      end else begin
         m_tog = 1'b0;
      end
      if (m_poss) begin
         if (!old_tog && m_tog) m_seen = 1'b1;
         else if (old_tog && !m_tog && m_seen) begin
            m_poss = 1'b0;
            m_seen = 1'b0;
         end
      end else if (poss_ev && st != 2) begin
         m_poss = 1'b1;
      end
      // level accepted once the last DEB synchronized samples all disagree with it
      for (int i = 0; i < 2; i++) begin
         raw      = (i == 0) ? btn_run_n : btn_poss_n;
         all_diff = 1'b1;
         for (int k = 1; k <= DEB; k++) if (hist[i][k] == m_deb[i]) all_diff = 1'b0;
         m_press[i] = 1'b0;
         if (all_diff) begin
            m_press[i] = m_deb[i];
            m_deb[i]   = !m_deb[i];
         end
         for (int k = DEB; k > 0; k--) hist[i][k] = hist[i][k-1];
         hist[i][0] = raw;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      chk("mdl_toggle",     int'(toggle),     int'(m_tog));
      chk("mdl_possession", int'(possession), int'(m_poss));
      chk("mdl_running",    int'(running),    int'(m_state == 1));
      chk("mdl_expired",    int'(expired),    int'(m_state == 2));
      chk("mdl_secs_left",  int'(secs_left),  m_secs);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_toggle"},     int'(toggle),     0);
      chk({tag, "_possession"}, int'(possession), 0);
      chk({tag, "_running"},    int'(running),    0);
      chk({tag, "_expired"},    int'(expired),    0);
      chk({tag, "_secs_left"},  int'(secs_left),  3);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset_n    = 1'b0;
      btn_run_n  = 1'b1;
      btn_poss_n = 1'b1;
      repeat (3) cyc();
      chk_reset_vals("rst0");
      reset_n = 1'b1;
      repeat (2) cyc();

      // bouncing run key: low 2, high 1, low 2, then high
      for (int e = 1; e <= 16; e++) begin
         btn_run_n = !(e == 1 || e == 2 || e == 4 || e == 5);
         cyc();
      end
      chk("bounce_running", int'(running), 0);
      chk("bounce_toggle",  int'(toggle),  0);

      // session 1: start, tick timing, possession handshake, expiry, presses after expiry
      for (int e = 1; e <= 56; e++) begin
         btn_run_n  = !((e >= 1 && e <= 8) || (e >= 40 && e <= 47));
         btn_poss_n = !((e >= 13 && e <= 18) || (e >= 23 && e <= 28));
         cyc();
         case (e)
            6:  chk("s1_running_before", int'(running), 0);
            7:  begin
                   chk("s1_running_at7", int'(running), 1);
                   chk("s1_toggle_at7",  int'(toggle),  0);
                end
            8:  begin
                   chk("s1_first_rise", int'(toggle),    1);
                   chk("s1_secs_rise1", int'(secs_left), 3);
                end
            12: chk("s1_high_last", int'(toggle), 1);
            13: chk("s1_fall",      int'(toggle), 0);
            17: chk("s1_low_last",  int'(toggle), 0);
            18: begin
                   chk("s1_second_rise", int'(toggle),     1);
                   chk("s1_secs_rise2",  int'(secs_left),  2);
                   chk("s1_poss_before", int'(possession), 0);
                end
            19: chk("s1_poss_set", int'(possession), 1);
            28: begin
                   chk("s1_secs_rise3",  int'(secs_left),  1);
                   chk("s1_poss_at_rise", int'(possession), 1);
                end
            32: chk("s1_poss_hold", int'(possession), 1);
            33: begin
                   chk("s1_poss_clear",  int'(possession), 0);
                   chk("s1_toggle_fell", int'(toggle),     0);
                end
            37: chk("s1_running_pre_exp", int'(running), 1);
            38: begin
                   chk("s1_secs_zero",     int'(secs_left), 0);
                   chk("s1_expired",       int'(expired),   1);
                   chk("s1_running_off",   int'(running),   0);
                end
            39: chk("s1_toggle_exp_low", int'(toggle), 0);
            56: begin
                   chk("s1_exp_sticky",   int'(expired),   1);
                   chk("s1_exp_not_run",  int'(running),   0);
                   chk("s1_exp_toggle",   int'(toggle),    0);
                   chk("s1_exp_secs",     int'(secs_left), 0);
                end
            default: ;
         endcase
      end

      reset_n = 1'b0;
      repeat (2) cyc();
      chk_reset_vals("rst1");
      reset_n = 1'b1;
      repeat (3) cyc();

      // session 2: stop coinciding with a tick rise, freeze, resume, async reset mid-run
      for (int e = 1; e <= 38; e++) begin
         btn_run_n  = !((e >= 1 && e <= 6) || (e >= 12 && e <= 17) || (e >= 24 && e <= 29));
         btn_poss_n = !(e >= 31 && e <= 36);
         cyc();
         case (e)
            7:  chk("s2_running", int'(running), 1);
            8:  begin
                   chk("s2_first_rise", int'(toggle),    1);
                   chk("s2_secs_rise1", int'(secs_left), 3);
                end
            17: begin
                   chk("s2_pre_stop_run", int'(running),   1);
                   chk("s2_pre_stop_tog", int'(toggle),    0);
                end
            18: begin
                   chk("s2_stop_wrap_tog",  int'(toggle),    1);
                   chk("s2_stop_wrap_secs", int'(secs_left), 2);
                   chk("s2_stop_wrap_run",  int'(running),   0);
                end
            25: begin
                   chk("s2_frozen_tog",  int'(toggle),    1);
                   chk("s2_frozen_secs", int'(secs_left), 2);
                end
            29: chk("s2_still_stopped", int'(running), 0);
            30: begin
                   chk("s2_resumed",     int'(running), 1);
                   chk("s2_resumed_tog", int'(toggle),  1);
                end
            34: chk("s2_rem_high", int'(toggle), 1);
            35: begin
                   chk("s2_rem_fall", int'(toggle),    0);
                   chk("s2_rem_secs", int'(secs_left), 2);
                end
            37: chk("s2_poss_set", int'(possession), 1);
            default: ;
         endcase
      end
      #2 reset_n = 1'b0;
      #1 chk_reset_vals("async_rst");
      repeat (2) cyc();
      reset_n = 1'b1;
      repeat (3) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
